// File: rtl/rs_alu_pkg.sv
// Purpose: shared constants for the integer ALU reservation station and the ALU behind it.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: default tag/opcode widths, data width, ALU opcode encodings (0 = no operation).
package rs_alu_pkg;

  localparam int RS_TAG_W = 5;
  localparam int RS_OP_W  = 7;
  localparam int XLEN     = 32;

  // ALU opcode encodings shared with the ALU; 0 marks an idle issue slot.
  localparam logic [RS_OP_W-1:0] OP_NOP   = 7'd0;
  localparam logic [RS_OP_W-1:0] OP_ADD   = 7'd1;
  localparam logic [RS_OP_W-1:0] OP_SUB   = 7'd2;
  localparam logic [RS_OP_W-1:0] OP_SLL   = 7'd3;
  localparam logic [RS_OP_W-1:0] OP_SLT   = 7'd4;
  localparam logic [RS_OP_W-1:0] OP_SLTU  = 7'd5;
  localparam logic [RS_OP_W-1:0] OP_XOR   = 7'd6;
  localparam logic [RS_OP_W-1:0] OP_SRL   = 7'd7;
  localparam logic [RS_OP_W-1:0] OP_SRA   = 7'd8;
  localparam logic [RS_OP_W-1:0] OP_OR    = 7'd9;
  localparam logic [RS_OP_W-1:0] OP_AND   = 7'd10;
  localparam logic [RS_OP_W-1:0] OP_BEQ   = 7'd11;
  localparam logic [RS_OP_W-1:0] OP_BNE   = 7'd12;
  localparam logic [RS_OP_W-1:0] OP_BLT   = 7'd13;
  localparam logic [RS_OP_W-1:0] OP_BGE   = 7'd14;
  localparam logic [RS_OP_W-1:0] OP_BLTU  = 7'd15;
  localparam logic [RS_OP_W-1:0] OP_BGEU  = 7'd16;
  localparam logic [RS_OP_W-1:0] OP_JAL   = 7'd17;
  localparam logic [RS_OP_W-1:0] OP_JALR  = 7'd18;
  localparam logic [RS_OP_W-1:0] OP_AUIPC = 7'd19;
  localparam logic [RS_OP_W-1:0] OP_LUI   = 7'd20;

endpackage

// File: rtl/rs_alu_select.sv
// Purpose: lowest-index priority encoder over a request vector.
// Latency: combinational.
// Backpressure: none.
// Ports: req (N request bits) -> found (any bit set), idx (lowest set bit, 0 when none).
module rs_alu_select #(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = i[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/rs_alu.sv
// Purpose: integer ALU reservation station; holds ops until both operands arrive, issues one per cycle.
// Latency: ready dispatch or CDB wakeup at edge E -> issue on registered alu_* outputs at edge E+1.
// Backpressure: full is raised when every entry is valid; dispatch while full is dropped.
// Ports: clk_in/rst_in (sync active-low)/rdy_in (stall)/flush_in; disp_* dispatch request; full;
//        cdb0_* (ALU result) and cdb1_* (LSB result) broadcasts; alu_* registered issue outputs.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = RS_TAG_W,
  parameter int OP_W    = RS_OP_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  // dispatch
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [XLEN-1:0]  disp_vi,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic             disp_qi_busy,
  input  logic             disp_qj_busy,
  input  logic [TAG_W-1:0] disp_qi,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [TAG_W-1:0] disp_tag,
  output logic             full,
  // result broadcasts
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [XLEN-1:0]  cdb0_val,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [XLEN-1:0]  cdb1_val,
  // issue
  output logic [OP_W-1:0]  alu_op,
  output logic [XLEN-1:0]  alu_vi,
  output logic [XLEN-1:0]  alu_vj,
  output logic [XLEN-1:0]  alu_imm,
  output logic [XLEN-1:0]  alu_pc,
  output logic [TAG_W-1:0] alu_rd
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vi;
    logic [XLEN-1:0]  vj;
    logic             qi_busy;
    logic             qj_busy;
    logic [TAG_W-1:0] qi;
    logic [TAG_W-1:0] qj;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t ent     [RS_SIZE];
  entry_t ent_nxt [RS_SIZE];
  entry_t disp_ent;

  logic [RS_SIZE-1:0] valid_vec;
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               iss_found;
  logic [IDX_W-1:0]   iss_idx;
  logic               disp_accept;

  // Operand capture: returns {busy, value}. cdb0 is checked first so it wins
  // a double match; both buses carry the same value for a tag anyway.
  function automatic logic [XLEN:0] wake(input logic busy,
                                         input logic [TAG_W-1:0] q,
                                         input logic [XLEN-1:0] v);
    wake = {busy, v};
    if (busy) begin
      if (cdb0_valid && (cdb0_tag == q)) begin
        wake = {1'b0, cdb0_val};
      end else if (cdb1_valid && (cdb1_tag == q)) begin
        wake = {1'b0, cdb1_val};
      end
    end
  endfunction

  // Candidate vectors are taken from registered state, so a wakeup this
  // cycle only makes the entry eligible on the following edge.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = ent[i].valid;
      free_vec[i]  = ~ent[i].valid;
      ready_vec[i] = ent[i].valid & ~ent[i].qi_busy & ~ent[i].qj_busy;
    end
  end

  assign full        = &valid_vec;
  assign disp_accept = disp_valid && !full && free_found;

  rs_alu_select #(.N(RS_SIZE)) u_free_sel (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_alu_select #(.N(RS_SIZE)) u_ready_sel (
    .req   (ready_vec),
    .found (iss_found),
    .idx   (iss_idx)
  );

  // New entry, with same-cycle forwarding from the CDBs.
  always_comb begin
    disp_ent       = '0;
    disp_ent.valid = 1'b1;
    disp_ent.op    = disp_op;
    disp_ent.qi    = disp_qi;
    disp_ent.qj    = disp_qj;
    disp_ent.imm   = disp_imm;
    disp_ent.pc    = disp_pc;
    disp_ent.tag   = disp_tag;
    {disp_ent.qi_busy, disp_ent.vi} = wake(disp_qi_busy, disp_qi, disp_vi);
    {disp_ent.qj_busy, disp_ent.vj} = wake(disp_qj_busy, disp_qj, disp_vj);
  end

  // Next-state of the entry array: wakeup, then free the issued slot, then
  // write the dispatched op. Issue and dispatch never hit the same slot since
  // one picks a valid entry and the other an invalid one.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].valid) begin
        {ent_nxt[i].qi_busy, ent_nxt[i].vi} = wake(ent[i].qi_busy, ent[i].qi, ent[i].vi);
        {ent_nxt[i].qj_busy, ent_nxt[i].vj} = wake(ent[i].qj_busy, ent[i].qj, ent[i].vj);
      end
    end
    if (iss_found) ent_nxt[iss_idx].valid = 1'b0;
    if (disp_accept) ent_nxt[free_idx] = disp_ent;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu_op  <= '0;
      alu_vi  <= '0;
      alu_vj  <= '0;
      alu_imm <= '0;
      alu_pc  <= '0;
      alu_rd  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
        alu_op <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) ent[i] <= ent_nxt[i];
        if (iss_found) begin
          alu_op  <= ent[iss_idx].op;
          alu_vi  <= ent[iss_idx].vi;
          alu_vj  <= ent[iss_idx].vj;
          alu_imm <= ent[iss_idx].imm;
          alu_pc  <= ent[iss_idx].pc;
          alu_rd  <= ent[iss_idx].tag;
        end else begin
          // Only the opcode marks an idle slot; operand fields keep their values.
          alu_op <= '0;
        end
      end
    end
  end

  // Dispatching into a full station is an upstream protocol error; the
  // request is dropped by disp_accept above.
  a_no_disp_when_full : assert property (
    @(posedge clk_in) disable iff (!rst_in)
    !(rdy_in && !flush_in && disp_valid && full)
  ) else $warning("rs_alu: dispatch while full dropped");

endmodule

// File: tb/tb_rs_alu.sv
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        disp_valid;
  logic [6:0]  disp_op;
  logic [31:0] disp_vi, disp_vj, disp_imm, disp_pc;
  logic        disp_qi_busy, disp_qj_busy;
  logic [4:0]  disp_qi, disp_qj, disp_tag;
  logic        full;
  logic        cdb0_valid, cdb1_valid;
  logic [4:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_val, cdb1_val;
  logic [6:0]  alu_op;
  logic [31:0] alu_vi, alu_vj, alu_imm, alu_pc;
  logic [4:0]  alu_rd;

  rs_alu #(.RS_SIZE(8), .TAG_W(5), .OP_W(7)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vi(disp_vi), .disp_vj(disp_vj),
    .disp_qi_busy(disp_qi_busy), .disp_qj_busy(disp_qj_busy),
    .disp_qi(disp_qi), .disp_qj(disp_qj), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_tag(disp_tag), .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
    .alu_op(alu_op), .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rd(alu_rd)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] vi, vj, imm, pc;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    exp_t e;
    e.op = op; e.vi = vi; e.vj = vj; e.imm = imm; e.pc = pc; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic expect_issue(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=scoreboard_empty expected=queued_entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".op"},  32'(alu_op),  32'(e.op));
      chk({tag, ".vi"},  alu_vi,       e.vi);
      chk({tag, ".vj"},  alu_vj,       e.vj);
      chk({tag, ".imm"}, alu_imm,      e.imm);
      chk({tag, ".pc"},  alu_pc,       e.pc);
      chk({tag, ".rd"},  32'(alu_rd),  32'(e.rd));
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".idle"}, 32'(alu_op), 32'(OP_NOP));
  endtask

  task automatic set_disp(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                          input logic qib, input logic [4:0] qi, input logic qjb, input logic [4:0] qj,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
    disp_valid = 1'b1; disp_op = op; disp_vi = vi; disp_vj = vj;
    disp_qi_busy = qib; disp_qi = qi; disp_qj_busy = qjb; disp_qj = qj;
    disp_imm = imm; disp_pc = pc; disp_tag = tag;
  endtask

  task automatic clr_in();
    disp_valid = 1'b0; disp_op = '0; disp_vi = '0; disp_vj = '0;
    disp_qi_busy = 1'b0; disp_qj_busy = 1'b0; disp_qi = '0; disp_qj = '0;
    disp_imm = '0; disp_pc = '0; disp_tag = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_val = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_val = '0;
    flush_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rdy_in = 1'b1;
    rst_in = 1'b0;

    // 1. reset state, then a ready ADD
    tick(); tick();
    chk("rst.op",  32'(alu_op), 32'h0);
    chk("rst.vi",  alu_vi,      32'h0);
    chk("rst.vj",  alu_vj,      32'h0);
    chk("rst.imm", alu_imm,     32'h0);
    chk("rst.pc",  alu_pc,      32'h0);
    chk("rst.rd",  32'(alu_rd), 32'h0);
    chk("rst.full", 32'(full),  32'h0);
    rst_in = 1'b1;
    set_disp(OP_ADD, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h11, 32'h100, 5'd3);
    push_exp(OP_ADD, 32'd5, 32'd7, 32'h11, 32'h100, 5'd3);
    tick(); clr_in();
    expect_idle("t1.disp_edge");
    tick();
    expect_issue("t1.issue");
    tick();
    expect_idle("t1.after");

    // 2. wakeup via cdb1
    set_disp(OP_SUB, 32'hBAD, 32'd2, 1'b1, 5'd9, 1'b0, 5'd0, 32'h22, 32'h104, 5'd10);
    tick(); clr_in();
    expect_idle("t2.wait0");
    tick();
    expect_idle("t2.wait1");
    cdb1_valid = 1'b1; cdb1_tag = 5'd9; cdb1_val = 32'd20;
    tick(); clr_in();
    expect_idle("t2.wake_edge");
    push_exp(OP_SUB, 32'd20, 32'd2, 32'h22, 32'h104, 5'd10);
    tick();
    expect_issue("t2.issue");

    // 3. same-cycle forwarding from cdb0
    set_disp(OP_XOR, 32'd1, 32'hDEAD, 1'b0, 5'd0, 1'b1, 5'd4, 32'h33, 32'h108, 5'd11);
    cdb0_valid = 1'b1; cdb0_tag = 5'd4; cdb0_val = 32'hFFFF_FFFF;
    push_exp(OP_XOR, 32'd1, 32'hFFFF_FFFF, 32'h33, 32'h108, 5'd11);
    tick(); clr_in();
    tick();
    expect_issue("t3.issue");

    // 4. fill all eight slots, overflow dispatch, ordered issue
    for (int i = 0; i < 8; i++) begin
      set_disp(OP_OR, 32'(i), 32'(i * 2), 1'b1, 5'd1, 1'b0, 5'd0,
               32'(i + 100), 32'(32'h200 + 4 * i), 5'(i + 8));
      tick(); clr_in();
      expect_idle("t4.fill");
    end
    chk("t4.full", 32'(full), 32'h1);
    set_disp(OP_AND, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h999, 5'd30);
    tick(); clr_in();
    chk("t4.full_after_overflow", 32'(full), 32'h1);
    expect_idle("t4.overflow");
    cdb0_valid = 1'b1; cdb0_tag = 5'd1; cdb0_val = 32'd100;
    tick(); clr_in();
    for (int i = 0; i < 8; i++)
      push_exp(OP_OR, 32'd100, 32'(i * 2), 32'(i + 100), 32'(32'h200 + 4 * i), 5'(i + 8));
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_issue($sformatf("t4.issue%0d", i));
      if (i == 0) chk("t4.full_drop", 32'(full), 32'h0);
    end
    tick();
    expect_idle("t4.no_overflow_issue");

    // 5. pause freezes state and outputs, then flush discards everything
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_SLT, 32'h0, 32'(i), 1'b1, 5'd6, 1'b0, 5'd0, 32'h0, 32'(32'h300 + 4 * i), 5'(i + 20));
      tick(); clr_in();
    end
    set_disp(OP_OR, 32'd8, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h44, 32'h310, 5'd23);
    push_exp(OP_OR, 32'd8, 32'd9, 32'h44, 32'h310, 5'd23);
    tick(); clr_in();
    tick();
    expect_issue("t5.pre_pause");
    rdy_in = 1'b0;
    cdb0_valid = 1'b1; cdb0_tag = 5'd6; cdb0_val = 32'd55;
    set_disp(OP_ADD, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h400, 5'd24);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5.frozen_op", 32'(alu_op), 32'(OP_OR));
      chk("t5.frozen_rd", 32'(alu_rd), 32'd23);
    end
    rdy_in = 1'b1;
    clr_in();
    tick();
    expect_idle("t5.no_capture0");
    tick();
    expect_idle("t5.no_capture1");
    flush_in = 1'b1;
    set_disp(OP_ADD, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h404, 5'd25);
    tick(); clr_in();
    expect_idle("t5.flush_edge");
    chk("t5.full", 32'(full), 32'h0);
    cdb0_valid = 1'b1; cdb0_tag = 5'd6; cdb0_val = 32'd55;
    tick(); clr_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("t5.after_flush");
    end

    // 6. reset in the middle of operation
    for (int i = 0; i < 5; i++) begin
      set_disp(OP_SLL, 32'h0, 32'h1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'(32'h500 + 4 * i), 5'(i + 1));
      tick(); clr_in();
    end
    set_disp(OP_BEQ, 32'd3, 32'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h10, 32'h600, 5'd12);
    push_exp(OP_BEQ, 32'd3, 32'd3, 32'h10, 32'h600, 5'd12);
    tick(); clr_in();
    tick();
    expect_issue("t6.beq");
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    chk("t6.rst_op",   32'(alu_op), 32'h0);
    chk("t6.rst_full", 32'(full),   32'h0);
    chk("t6.rst_pc",   alu_pc,      32'h0);
    cdb0_valid = 1'b1; cdb0_tag = 5'd7; cdb0_val = 32'd77;
    tick(); clr_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("t6.no_stale");
    end
    set_disp(OP_LUI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'hABCD_0000, 32'h700, 5'd31);
    push_exp(OP_LUI, 32'd0, 32'd0, 32'hABCD_0000, 32'h700, 5'd31);
    tick(); clr_in();
    tick();
    expect_issue("t6.post_reset");
    chk("sb.drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
